// File: rtl/ahb_lite_slave_mux_n.sv
// AHB-Lite address decoder and data-phase response mux for SLV_CNT slaves plus a built-in ERROR default slave.
// Optional stalled-slave watchdog with quarantine: define AHB_MUX_TIMEOUT_EN.
module ahb_lite_slave_mux_n #(
  parameter int unsigned                     SLV_CNT        = 3,
  parameter int unsigned                     AHB_WIDTH      = 32,
  parameter logic [SLV_CNT*AHB_WIDTH-1:0]    SLV_BASE       = {32'hF000_0000, 32'hFFFE_0000, 32'hFFDF_0000},
  parameter logic [SLV_CNT*AHB_WIDTH-1:0]    SLV_MASK       = {32'hFF00_0000, 32'hFFFE_0000, 32'hFFFF_0000},
  parameter int unsigned                     TIMEOUT_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [AHB_WIDTH-1:0]           m_haddr,
  input  logic [1:0]                     m_htrans,
  output logic [AHB_WIDTH-1:0]           m_hrdata,
  output logic                           m_hready,
  output logic                           m_hresp,
  output logic [SLV_CNT-1:0]             s_hsel,
  input  logic [SLV_CNT-1:0]             s_hreadyout,
  input  logic [SLV_CNT-1:0]             s_hresp,
`ifdef AHB_MUX_TIMEOUT_EN
  input  logic [SLV_CNT*AHB_WIDTH-1:0]   s_hrdata,
  output logic                           err_timeout
`else
  input  logic [SLV_CNT*AHB_WIDTH-1:0]   s_hrdata
`endif
);

  localparam int unsigned IDX_W = (SLV_CNT > 1) ? $clog2(SLV_CNT) : 1;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SLV  = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       owner;
  logic [SLV_CNT-1:0]     hit;
  logic [SLV_CNT-1:0]     hit_ok;
  logic                   any_hit;
  logic [IDX_W-1:0]       win_idx;
  logic [AHB_WIDTH-1:0]   rdata_arr [SLV_CNT];

  // Raw address decode against every base/mask pair
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(SLV_CNT); i++) begin
      hit[i] = ((m_haddr & SLV_MASK[i*AHB_WIDTH +: AHB_WIDTH]) == SLV_BASE[i*AHB_WIDTH +: AHB_WIDTH]);
    end
  end

`ifdef AHB_MUX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SLV_CNT-1:0]     quar;
  logic [CNT_W-1:0]       stall_cnt;
  logic                   timeout_hit;

  assign hit_ok      = hit & ~quar;
  assign timeout_hit = (state == ST_SLV) && !s_hreadyout[owner] &&
                       (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign hit_ok = hit;
`endif

  // Lowest-index hit wins on overlap
  always_comb begin
    any_hit = 1'b0;
    win_idx = '0;
    for (int i = 0; i < int'(SLV_CNT); i++) begin
      if (hit_ok[i] && !any_hit) begin
        any_hit = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
    s_hsel = any_hit ? (SLV_CNT'(1) << win_idx) : '0;
  end

  for (genvar g = 0; g < SLV_CNT; g++) begin : g_rdata
    assign rdata_arr[g] = s_hrdata[g*AHB_WIDTH +: AHB_WIDTH];
  end

  // Data-phase response follows the registered owner
  always_comb begin
    m_hready = 1'b1;
    m_hresp  = 1'b0;
    m_hrdata = '0;
    case (state)
      ST_SLV: begin
        m_hready = s_hreadyout[owner];
        m_hresp  = s_hresp[owner];
        m_hrdata = rdata_arr[owner];
      end
      ST_ERR1: begin
        m_hready = 1'b0;
        m_hresp  = 1'b1;
      end
      ST_ERR2: m_hresp = 1'b1;
      default: ;
    endcase
  end

  // Owner FSM: a new owner is latched only while m_hready is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_NONE;
      owner <= '0;
`ifdef AHB_MUX_TIMEOUT_EN
      quar        <= '0;
      stall_cnt   <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
`ifdef AHB_MUX_TIMEOUT_EN
      err_timeout <= 1'b0;
      quar        <= quar & ~s_hreadyout;
      stall_cnt   <= '0;
`endif
      if (state == ST_ERR1) begin
        state <= ST_ERR2;
      end else if (m_hready) begin
        if (!m_htrans[1]) begin
          state <= ST_NONE;
        end else if (any_hit) begin
          state <= ST_SLV;
          owner <= win_idx;
        end else begin
          state <= ST_ERR1;
        end
      end
`ifdef AHB_MUX_TIMEOUT_EN
      else if (timeout_hit) begin
        state       <= ST_ERR1;
        quar[owner] <= 1'b1;
        err_timeout <= 1'b1;
      end else if (state == ST_SLV) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
`endif
    end
  end

endmodule
